i2_router_fifo_rdctrl: RTL and testbench



---
 rtl/i2_router_fifo_rdctrl_pkg.sv | 27 ++
 rtl/i2_router_fifo_rdctrl_if.sv | 27 ++
 rtl/i2_router_fifo_rdctrl.sv | 121 ++++++++++++
 tb/tb_i2_router_fifo_rdctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2_router_fifo_rdctrl_pkg.sv
// Shared definitions for the i2 router input-FIFO controllers: flit type codes,
// read-controller state encoding and the flit type-field extractor.
package i2_router_fifo_rdctrl_pkg;

   localparam int unsigned FLIT_TYPE_W = 3;
   localparam int unsigned FLIT_W_MAX  = 256;
   localparam int unsigned CNT_W       = 8;

   typedef logic [FLIT_TYPE_W-1:0] flit_type_t;
   typedef logic [FLIT_W_MAX-1:0]  flit_word_t;
   typedef logic [CNT_W-1:0]       flit_cnt_t;

   localparam flit_type_t FLIT_HEAD = 3'b001;
   localparam flit_type_t FLIT_TAIL = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Type code sits in the top three bits of a data_w-wide flit; callers
   // zero-extend their flit to flit_word_t.
   function automatic flit_type_t flit_type(input flit_word_t flit, input int unsigned data_w);
      return flit_type_t'(flit >> (data_w - FLIT_TYPE_W));
   endfunction

endpackage

// File: rtl/i2_router_fifo_rdctrl_if.sv
// FIFO read port plus the two router req/bussy output ports of the read controller.
interface i2_router_fifo_rdctrl_if #(
   parameter int unsigned DATA_W = 32
);

   logic              FIFO_empty;
   logic [DATA_W-1:0] FIFO_dout;
   logic              FIFO_rd;
   logic              output_req1;
   logic              output_bussy1;
   logic              output_req2;
   logic              output_bussy2;
   logic [DATA_W-1:0] flit_out;
   logic              select;
   logic              pkt_err;

   modport master (
      input  FIFO_empty, FIFO_dout, output_bussy1, output_bussy2,
      output FIFO_rd, output_req1, output_req2, flit_out, select, pkt_err
   );

   modport slave (
      output FIFO_empty, FIFO_dout, output_bussy1, output_bussy2,
      input  FIFO_rd, output_req1, output_req2, flit_out, select, pkt_err
   );

endinterface

// File: rtl/i2_router_fifo_rdctrl.sv
// Read-side controller of the i2 router input FIFO: routes each packet to one of
// two output ports from the head flit's destination bit and flags framing errors.
module i2_router_fifo_rdctrl
   import i2_router_fifo_rdctrl_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEST_BIT    = 0,
   parameter int unsigned MAX_PKT_LEN = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   i2_router_fifo_rdctrl_if.master bus
);

   localparam flit_cnt_t MAX_LEN = flit_cnt_t'(MAX_PKT_LEN);

   state_t    state_q, state_d;
   logic      port_q, port_d;
   flit_cnt_t cnt_q, cnt_d;
   logic      err_q, err_d;

   flit_type_t head_type;
   logic       is_head;
   logic       is_tail;
   logic       port_bussy;
   logic       misplaced_head;
   logic       send_req;
   logic       accept;

   assign head_type = flit_type(flit_word_t'(bus.FIFO_dout), DATA_W);
   assign is_head   = (head_type == FLIT_HEAD);
   assign is_tail   = (head_type == FLIT_TAIL);

   // Only the bussy of the port owning the current packet matters.
   assign port_bussy = port_q ? bus.output_bussy2 : bus.output_bussy1;

   // A head behind the packet's own head is left in the FIFO to start a new packet.
   assign misplaced_head = !bus.FIFO_empty && is_head && (cnt_q > flit_cnt_t'(1));
   assign send_req       = (state_q == SEND) && !bus.FIFO_empty && !misplaced_head;
   assign accept         = send_req && !port_bussy;

   assign bus.flit_out = bus.FIFO_dout;
   assign bus.pkt_err  = err_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (!bus.FIFO_empty) begin
               if (is_head) begin
                  state_d = SEND;
                  port_d  = bus.FIFO_dout[DEST_BIT];
                  cnt_d   = flit_cnt_t'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (misplaced_head) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (accept) begin
               if (is_tail) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q >= MAX_LEN) begin
                  // Overlong packet: abort; its leftover flits drain as orphans.
                  state_d = IDLE;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + flit_cnt_t'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.FIFO_rd     = 1'b0;
      bus.output_req1 = 1'b0;
      bus.output_req2 = 1'b0;
      bus.select      = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: bus.FIFO_rd = !bus.FIFO_empty && !is_head;
            SEND: begin
               bus.select      = port_q;
               bus.output_req1 = send_req && !port_q;
               bus.output_req2 = send_req && port_q;
               bus.FIFO_rd     = accept;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2_router_fifo_rdctrl.sv
// Bench for i2_router_fifo_rdctrl: per-cycle vector table plus a flit scoreboard
// fed from a queue model of the first-word-fall-through FIFO.
module tb_i2_router_fifo_rdctrl;

   localparam int unsigned DATA_W = 32;

   typedef struct {
      string tag;
      int    push;
      logic  rst;
      logic  b1;
      logic  b2;
      logic  rd;
      logic  r1;
      logic  r2;
      logic  sel;
      logic  err;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] flit;
      logic              deliver;
      logic              port;
   } src_t;

   typedef struct {
      logic [DATA_W-1:0] flit;
      logic              port;
   } sb_t;

   logic clk;
   logic rst;

   i2_router_fifo_rdctrl_if #(.DATA_W(DATA_W)) bus ();

   i2_router_fifo_rdctrl #(
      .DATA_W(DATA_W),
      .DEST_BIT(0),
      .MAX_PKT_LEN(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DATA_W-1:0] fifo_q[$];
   src_t              src_q[$];
   sb_t               exp_q[$];
   vec_t              vecs[$];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] mkf(input logic [2:0] t, input logic dest,
                                             input logic [7:0] id);
      return {t, 20'h0, id, dest};
   endfunction

   function automatic vec_t mk_vec(input string tag, input int push, input logic r,
                                   input logic b1, input logic b2, input logic rd,
                                   input logic r1, input logic r2, input logic sel,
                                   input logic err);
      vec_t v;
      v.tag = tag; v.push = push; v.rst = r; v.b1 = b1; v.b2 = b2;
      v.rd = rd; v.r1 = r1; v.r2 = r2; v.sel = sel; v.err = err;
      return v;
   endfunction

   task automatic add(input string tag, input int push, input logic r, input logic b1,
                      input logic b2, input logic rd, input logic r1, input logic r2,
                      input logic sel, input logic err);
      vecs.push_back(mk_vec(tag, push, r, b1, b2, rd, r1, r2, sel, err));
   endtask

   task automatic src(input logic [2:0] t, input logic dest, input logic [7:0] id,
                      input logic deliver);
      src_t s;
      s.flit = mkf(t, dest, id); s.deliver = deliver; s.port = dest;
      src_q.push_back(s);
   endtask

   task automatic push_flit(input logic [DATA_W-1:0] flit, input logic deliver,
                            input logic port);
      sb_t e;
      fifo_q.push_back(flit);
      if (deliver) begin
         e.flit = flit; e.port = port;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_fifo();
      bus.FIFO_empty = (fifo_q.size() == 0);
      bus.FIFO_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic sb_take(input string tag, input logic port);
      sb_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_sb: unexpected transfer on port %0d, expected none", tag, port);
      end else begin
         e = exp_q.pop_front();
         check_bit({tag, "_sb_port"}, port, e.port);
         check_word({tag, "_sb_flit"}, bus.flit_out, e.flit);
      end
   endtask

   // One clock: drive at the negedge, compare 1 time unit later, pop on the posedge.
   task automatic step(input vec_t v);
      logic popped;
      rst               = v.rst;
      bus.output_bussy1 = v.b1;
      bus.output_bussy2 = v.b2;
      drive_fifo();
      #1;
      check_bit({v.tag, "_rd"},   bus.FIFO_rd,     v.rd);
      check_bit({v.tag, "_req1"}, bus.output_req1, v.r1);
      check_bit({v.tag, "_req2"}, bus.output_req2, v.r2);
      check_bit({v.tag, "_sel"},  bus.select,      v.sel);
      check_bit({v.tag, "_err"},  bus.pkt_err,     v.err);
      if (fifo_q.size() != 0) check_word({v.tag, "_flit_out"}, bus.flit_out, fifo_q[0]);
      if (bus.output_req1 && !bus.output_bussy1) sb_take(v.tag, 1'b0);
      if (bus.output_req2 && !bus.output_bussy2) sb_take(v.tag, 1'b1);
      popped = bus.FIFO_rd;
      @(posedge clk);
      if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
      @(negedge clk);
   endtask

   initial begin
      // ---- stimulus table: tag, push, rst, b1, b2 | rd, req1, req2, sel, err
      // Basic 3-flit packet to port 1.
      src(3'b001, 1'b0, 8'h10, 1'b1); src(3'b000, 1'b0, 8'h11, 1'b1); src(3'b110, 1'b0, 8'h12, 1'b1);
      add("s1_route", 3, 0, 0, 0, 0, 0, 0, 0, 0);
      add("s1_head",  0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("s1_body",  0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("s1_tail",  0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("s1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Port 2 with backpressure on the body flit; bussy1 toggles and is ignored.
      src(3'b001, 1'b1, 8'h20, 1'b1); src(3'b011, 1'b1, 8'h21, 1'b1); src(3'b110, 1'b1, 8'h22, 1'b1);
      add("s2_route", 3, 0, 1, 0, 0, 0, 0, 0, 0);
      add("s2_head",  0, 0, 1, 0, 1, 0, 1, 1, 0);
      add("s2_bsy_a", 0, 0, 1, 1, 0, 0, 1, 1, 0);
      add("s2_bsy_b", 0, 0, 0, 1, 0, 0, 1, 1, 0);
      add("s2_body",  0, 0, 1, 0, 1, 0, 1, 1, 0);
      add("s2_tail",  0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("s2_idle",  0, 0, 1, 0, 0, 0, 0, 0, 0);
      // FIFO runs dry for 3 cycles before the tail arrives.
      src(3'b001, 1'b1, 8'h30, 1'b1); src(3'b111, 1'b1, 8'h31, 1'b1); src(3'b110, 1'b1, 8'h32, 1'b1);
      add("s3_route", 2, 0, 0, 0, 0, 0, 0, 0, 0);
      add("s3_head",  0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("s3_body",  0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("s3_gap_a", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("s3_gap_b", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("s3_gap_c", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("s3_tail",  1, 0, 0, 0, 1, 0, 1, 1, 0);
      add("s3_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Packet of exactly MAX_PKT_LEN flits ending in a tail is legal.
      src(3'b001, 1'b0, 8'h40, 1'b1); src(3'b000, 1'b0, 8'h41, 1'b1);
      src(3'b010, 1'b0, 8'h42, 1'b1); src(3'b110, 1'b0, 8'h43, 1'b1);
      add("m_route",  4, 0, 0, 0, 0, 0, 0, 0, 0);
      add("m_f1",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("m_f2",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("m_f3",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("m_f4",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("m_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Orphan body flit in IDLE.
      src(3'b000, 1'b0, 8'h50, 1'b0);
      add("o_pop",    1, 0, 0, 0, 1, 0, 0, 0, 0);
      add("o_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1);
      add("rst_a",    0, 1, 0, 0, 0, 0, 0, 0, 1);
      // Five flits, no tail: four go out, the fifth is an orphan.
      src(3'b001, 1'b1, 8'h60, 1'b1); src(3'b000, 1'b1, 8'h61, 1'b1);
      src(3'b000, 1'b1, 8'h62, 1'b1); src(3'b000, 1'b1, 8'h63, 1'b1);
      src(3'b000, 1'b1, 8'h64, 1'b0);
      add("l_route",  5, 0, 0, 0, 0, 0, 0, 0, 0);
      add("l_f1",     0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("l_f2",     0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("l_f3",     0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("l_f4",     0, 0, 0, 0, 1, 0, 1, 1, 0);
      add("l_orph",   0, 0, 0, 0, 1, 0, 0, 0, 1);
      add("l_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1);
      add("rst_b",    0, 1, 0, 0, 0, 0, 0, 0, 1);
      // Second head before a tail: left in the FIFO and routed as a new packet.
      src(3'b001, 1'b0, 8'h70, 1'b1); src(3'b000, 1'b0, 8'h71, 1'b1);
      src(3'b001, 1'b1, 8'h72, 1'b1); src(3'b000, 1'b1, 8'h73, 1'b1);
      src(3'b110, 1'b1, 8'h74, 1'b1);
      add("h_route",  5, 0, 0, 0, 0, 0, 0, 0, 0);
      add("h_f1",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("h_f2",     0, 0, 0, 0, 1, 1, 0, 0, 0);
      add("h_dup",    0, 0, 0, 0, 0, 0, 0, 0, 0);
      add("h_reroute",0, 0, 0, 0, 0, 0, 0, 0, 1);
      add("h_g1",     0, 0, 0, 0, 1, 0, 1, 1, 1);
      add("h_g2",     0, 0, 0, 0, 1, 0, 1, 1, 1);
      add("h_g3",     0, 0, 0, 0, 1, 0, 1, 1, 1);
      add("h_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1);

      // ---- reset
      rst = 1'b1;
      bus.output_bussy1 = 1'b0;
      bus.output_bussy2 = 1'b0;
      drive_fifo();
      @(posedge clk);
      @(negedge clk);
      step(mk_vec("init_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0));

      // ---- table
      foreach (vecs[i]) begin
         for (int k = 0; k < vecs[i].push; k++) begin
            src_t s;
            s = src_q.pop_front();
            push_flit(s.flit, s.deliver, s.port);
         end
         step(vecs[i]);
      end

      // ---- reset in the middle of a packet, then a fresh packet
      push_flit(mkf(3'b001, 1'b0, 8'h80), 1'b1, 1'b0);
      push_flit(mkf(3'b000, 1'b0, 8'h81), 1'b0, 1'b0);
      push_flit(mkf(3'b110, 1'b0, 8'h82), 1'b0, 1'b0);
      step(mk_vec("r6_route", 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(mk_vec("r6_head",  0, 0, 0, 0, 1, 1, 0, 0, 1));
      step(mk_vec("r6_rst",   0, 1, 1, 1, 0, 0, 0, 0, 1));
      fifo_q.delete();
      push_flit(mkf(3'b001, 1'b1, 8'h90), 1'b1, 1'b1);
      push_flit(mkf(3'b110, 1'b1, 8'h91), 1'b1, 1'b1);
      step(mk_vec("r6_route2", 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk_vec("r6_head2",  0, 0, 0, 0, 1, 0, 1, 1, 0));
      step(mk_vec("r6_tail2",  0, 0, 0, 0, 1, 0, 1, 1, 0));
      step(mk_vec("r6_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0));

      check_word("sb_drained",   DATA_W'(exp_q.size()),  '0);
      check_word("fifo_drained", DATA_W'(fifo_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
